// File: rtl/pe_vc_injector.sv
// -----------------------------------------------------------------------------
// pe_vc_injector
//
// PE-to-router injection stage for the mesh NoC. The PE writes flits into one
// of ViCh per-virtual-channel FIFOs. A round-robin arbiter drains the FIFOs
// into the router local input port, one flit per cycle, and only drains a VC
// whose router-side buffer has signalled space. With PacketMode=1 the arbiter
// stays on one VC for PktLen consecutive flits. While it does so, cycles in
// which that VC cannot send are bubbles.
//
// Ports
//   clock         in   rising-edge clock
//   reset         in   synchronous, active-high
//   PE_OutpData   in   flit from the PE
//   PE_OutpEn     in   PE write strobe
//   PE_OutpSel    in   target VC of the write
//   PE_OutpReady  out  combinational: selected FIFO not full and Sel in range
//   Ro_InpData    out  registered flit to the router
//   Ro_InpEn      out  registered one-cycle flit strobe
//   Ro_InpSel     out  registered VC of the flit
//   Ro_InpReady   in   per-VC router space (guarantees room for next-cycle flit)
//   VcFull        out  per-VC FIFO full, decoded from the count registers
//   VcEmpty       out  per-VC FIFO empty, decoded from the count registers
// -----------------------------------------------------------------------------
module pe_vc_injector #(
    parameter int DataWidth  = 8,
    parameter int ViCh       = 2,
    parameter int ViChAddr   = 1,
    parameter int FifoDepth  = 4,
    parameter int FifoAddr   = 2,
    parameter int PacketMode = 0,
    parameter int PktLen     = 4,
    parameter int PktCntW    = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DataWidth-1:0] PE_OutpData,
    input  logic                 PE_OutpEn,
    input  logic [ViChAddr-1:0]  PE_OutpSel,
    output logic                 PE_OutpReady,
    output logic [DataWidth-1:0] Ro_InpData,
    output logic                 Ro_InpEn,
    output logic [ViChAddr-1:0]  Ro_InpSel,
    input  logic [ViCh-1:0]      Ro_InpReady,
    output logic [ViCh-1:0]      VcFull,
    output logic [ViCh-1:0]      VcEmpty
);

    localparam int CntW = FifoAddr + 1;
    localparam logic [CntW-1:0]    CntFull = CntW'(FifoDepth);
    localparam logic [CntW-1:0]    CntZero = {CntW{1'b0}};
    localparam logic [PktCntW-1:0] PktLast = PktCntW'(PktLen - 1);
    // A one-flit packet is indistinguishable from flit mode, so locking is
    // only used when a packet spans more than one flit.
    localparam bit PktEn = (PacketMode != 0) && (PktLen > 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    // Wrap a FIFO pointer modulo FifoDepth.
    function automatic logic [FifoAddr-1:0] ptr_inc(input logic [FifoAddr-1:0] p);
        if (p == FifoAddr'(FifoDepth - 1)) begin
            return {FifoAddr{1'b0}};
        end else begin
            return p + FifoAddr'(1);
        end
    endfunction

    // Wrap a VC index modulo ViCh.
    function automatic logic [ViChAddr-1:0] vc_inc(input logic [ViChAddr-1:0] v);
        if (v == ViChAddr'(ViCh - 1)) begin
            return {ViChAddr{1'b0}};
        end else begin
            return v + ViChAddr'(1);
        end
    endfunction

    // State registers and their next-state values
    logic [DataWidth-1:0] mem_q   [ViCh][FifoDepth];
    logic [DataWidth-1:0] mem_d   [ViCh][FifoDepth];
    logic [CntW-1:0]      cnt_q   [ViCh];
    logic [CntW-1:0]      cnt_d   [ViCh];
    logic [FifoAddr-1:0]  wptr_q  [ViCh];
    logic [FifoAddr-1:0]  wptr_d  [ViCh];
    logic [FifoAddr-1:0]  rptr_q  [ViCh];
    logic [FifoAddr-1:0]  rptr_d  [ViCh];
    logic [ViChAddr-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ViChAddr-1:0]  lock_vc_q, lock_vc_d;
    logic [PktCntW-1:0]   pkt_cnt_q, pkt_cnt_d;
    state_t               state_q, state_d;
    logic [DataWidth-1:0] ro_data_q, ro_data_d;
    logic                 ro_en_q, ro_en_d;
    logic [ViChAddr-1:0]  ro_sel_q, ro_sel_d;

    // Combinational helpers
    logic [ViCh-1:0]      vc_full_s;
    logic [ViCh-1:0]      vc_empty_s;
    logic [ViCh-1:0]      eligible_s;
    logic                 ready_s;
    logic                 wr_s;
    logic [ViCh-1:0]      push_s;
    logic [ViCh-1:0]      pop_s;
    logic                 gnt_valid_s;
    logic [ViChAddr-1:0]  gnt_vc_s;
    logic [ViChAddr-1:0]  rr_idx_s;
    logic [DataWidth-1:0] head_s;

    // Per-VC status flags, decoded only from the count registers
    always_comb begin
        vc_full_s  = {ViCh{1'b0}};
        vc_empty_s = {ViCh{1'b0}};
        eligible_s = {ViCh{1'b0}};
        for (int v = 0; v < ViCh; v++) begin
            vc_full_s[v]  = (cnt_q[v] == CntFull);
            vc_empty_s[v] = (cnt_q[v] == CntZero);
            eligible_s[v] = (cnt_q[v] != CntZero) && Ro_InpReady[v];
        end
    end

    // PE-side ready: an out-of-range Sel matches no VC and so reads as not ready.
    // Uses the pre-edge count, so a full FIFO refuses even if it pops this cycle.
    always_comb begin
        ready_s = 1'b0;
        for (int v = 0; v < ViCh; v++) begin
            ready_s = ready_s | ((PE_OutpSel == ViChAddr'(v)) & ~vc_full_s[v]);
        end
    end

    // Arbiter: in LOCK only the locked VC may send; otherwise round robin from
    // rr_ptr. Scanning offsets high-to-low lets the lowest offset win last.
    always_comb begin
        gnt_valid_s = 1'b0;
        gnt_vc_s    = {ViChAddr{1'b0}};
        rr_idx_s    = {ViChAddr{1'b0}};
        if (PktEn && (state_q == ST_LOCK)) begin
            gnt_valid_s = eligible_s[lock_vc_q];
            gnt_vc_s    = lock_vc_q;
        end else begin
            for (int i = ViCh - 1; i >= 0; i--) begin
                rr_idx_s = ViChAddr'((int'(rr_ptr_q) + i) % ViCh);
                if (eligible_s[rr_idx_s]) begin
                    gnt_valid_s = 1'b1;
                    gnt_vc_s    = rr_idx_s;
                end else begin
                    gnt_valid_s = gnt_valid_s;
                end
            end
        end
    end

    // Push/pop decode per VC and the flit at the head of the granted FIFO
    always_comb begin
        wr_s   = PE_OutpEn & ready_s;
        push_s = {ViCh{1'b0}};
        pop_s  = {ViCh{1'b0}};
        for (int v = 0; v < ViCh; v++) begin
            push_s[v] = wr_s && (PE_OutpSel == ViChAddr'(v));
            pop_s[v]  = gnt_valid_s && (gnt_vc_s == ViChAddr'(v));
        end
        head_s = mem_q[gnt_vc_s][rptr_q[gnt_vc_s]];
    end

    // Next-state: FIFO storage, pointers, counts, output register, arbiter FSM
    always_comb begin
        mem_d     = mem_q;
        cnt_d     = cnt_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        rr_ptr_d  = rr_ptr_q;
        lock_vc_d = lock_vc_q;
        pkt_cnt_d = pkt_cnt_q;
        state_d   = state_q;
        ro_data_d = ro_data_q;
        ro_sel_d  = ro_sel_q;
        ro_en_d   = gnt_valid_s;

        for (int v = 0; v < ViCh; v++) begin
            if (push_s[v]) begin
                mem_d[v][wptr_q[v]] = PE_OutpData;
                wptr_d[v]           = ptr_inc(wptr_q[v]);
            end else begin
                wptr_d[v] = wptr_q[v];
            end
            if (pop_s[v]) begin
                rptr_d[v] = ptr_inc(rptr_q[v]);
            end else begin
                rptr_d[v] = rptr_q[v];
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({push_s[v], pop_s[v]})
                2'b10:   cnt_d[v] = cnt_q[v] + CntW'(1);
                2'b01:   cnt_d[v] = cnt_q[v] - CntW'(1);
                default: cnt_d[v] = cnt_q[v];
            endcase
        end

        if (gnt_valid_s) begin
            ro_data_d = head_s;
            ro_sel_d  = gnt_vc_s;
            rr_ptr_d  = vc_inc(gnt_vc_s);
        end else begin
            ro_data_d = ro_data_q;
            ro_sel_d  = ro_sel_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (PktEn && gnt_valid_s) begin
                    state_d   = ST_LOCK;
                    lock_vc_d = gnt_vc_s;
                    pkt_cnt_d = PktCntW'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCK: begin
                if (gnt_valid_s && (pkt_cnt_q == PktLast)) begin
                    pkt_cnt_d = {PktCntW{1'b0}};
                    rr_ptr_d  = vc_inc(lock_vc_q);
                    state_d   = ST_IDLE;
                end else if (gnt_valid_s) begin
                    pkt_cnt_d = pkt_cnt_q + PktCntW'(1);
                end else begin
                    state_d = ST_LOCK;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                pkt_cnt_d = {PktCntW{1'b0}};
            end
        endcase
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int v = 0; v < ViCh; v++) begin
                cnt_q[v]  <= CntZero;
                wptr_q[v] <= {FifoAddr{1'b0}};
                rptr_q[v] <= {FifoAddr{1'b0}};
            end
            rr_ptr_q  <= {ViChAddr{1'b0}};
            lock_vc_q <= {ViChAddr{1'b0}};
            pkt_cnt_q <= {PktCntW{1'b0}};
            state_q   <= ST_IDLE;
            ro_data_q <= {DataWidth{1'b0}};
            ro_en_q   <= 1'b0;
            ro_sel_q  <= {ViChAddr{1'b0}};
        end else begin
            cnt_q     <= cnt_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_vc_q <= lock_vc_d;
            pkt_cnt_q <= pkt_cnt_d;
            state_q   <= state_d;
            ro_data_q <= ro_data_d;
            ro_en_q   <= ro_en_d;
            ro_sel_q  <= ro_sel_d;
        end
    end

    // FIFO storage; contents need no reset because counts gate every read
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign PE_OutpReady = ready_s;
    assign Ro_InpData   = ro_data_q;
    assign Ro_InpEn     = ro_en_q;
    assign Ro_InpSel    = ro_sel_q;
    assign VcFull       = vc_full_s;
    assign VcEmpty      = vc_empty_s;

endmodule

// File: tb/tb_pe_vc_injector.sv
// -----------------------------------------------------------------------------
// tb_pe_vc_injector
//
// Directed bench for pe_vc_injector. Two instances share clock, reset and all
// inputs: u_flit runs flit-level round robin, u_pkt runs packet mode with
// PktLen=4. Each task drives one scenario and compares outputs against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_pe_vc_injector;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] pe_data;
    logic       pe_en;
    logic       pe_sel;
    logic [1:0] ro_ready;

    logic       f_ready, f_en, f_sel;
    logic [7:0] f_data;
    logic [1:0] f_full, f_empty;
    logic       p_ready, p_en, p_sel;
    logic [7:0] p_data;
    logic [1:0] p_full, p_empty;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    pe_vc_injector #(.PacketMode(0)) u_flit (
        .clock        (clock),
        .reset        (reset),
        .PE_OutpData  (pe_data),
        .PE_OutpEn    (pe_en),
        .PE_OutpSel   (pe_sel),
        .PE_OutpReady (f_ready),
        .Ro_InpData   (f_data),
        .Ro_InpEn     (f_en),
        .Ro_InpSel    (f_sel),
        .Ro_InpReady  (ro_ready),
        .VcFull       (f_full),
        .VcEmpty      (f_empty)
    );

    pe_vc_injector #(.PacketMode(1), .PktLen(4)) u_pkt (
        .clock        (clock),
        .reset        (reset),
        .PE_OutpData  (pe_data),
        .PE_OutpEn    (pe_en),
        .PE_OutpSel   (pe_sel),
        .PE_OutpReady (p_ready),
        .Ro_InpData   (p_data),
        .Ro_InpEn     (p_en),
        .Ro_InpSel    (p_sel),
        .Ro_InpReady  (ro_ready),
        .VcFull       (p_full),
        .VcEmpty      (p_empty)
    );

    // Advance one clock; registered outputs are stable 2 time units after the edge.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        pe_en    = 1'b0;
        pe_sel   = 1'b0;
        pe_data  = 8'h00;
        ro_ready = 2'b00;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One-cycle PE write; consecutive calls give back-to-back writes.
    task automatic write_flit(input logic sel, input logic [7:0] d);
        pe_en   = 1'b1;
        pe_sel  = sel;
        pe_data = d;
        tick();
        pe_en = 1'b0;
    endtask

    task automatic test_reset();
        // A write held during reset must be ignored.
        reset    = 1'b1;
        pe_en    = 1'b1;
        pe_sel   = 1'b1;
        pe_data  = 8'hEE;
        ro_ready = 2'b11;
        tick();
        tick();
        reset  = 1'b0;
        pe_en  = 1'b0;
        pe_sel = 1'b0;
        tick();
        #1;
        n_vec++;
        if ({f_en, f_data, f_sel, f_empty, f_full, f_ready} !== {1'b0, 8'h00, 1'b0, 2'b11, 2'b00, 1'b1}) begin
            n_err++;
            $display("FAIL reset_flit: en/data/sel/empty/full/ready got %b/%h/%b/%b/%b/%b want 0/00/0/11/00/1",
                     f_en, f_data, f_sel, f_empty, f_full, f_ready);
        end
        n_vec++;
        if ({p_en, p_data, p_sel, p_empty, p_full, p_ready} !== {1'b0, 8'h00, 1'b0, 2'b11, 2'b00, 1'b1}) begin
            n_err++;
            $display("FAIL reset_pkt: en/data/sel/empty/full/ready got %b/%h/%b/%b/%b/%b want 0/00/0/11/00/1",
                     p_en, p_data, p_sel, p_empty, p_full, p_ready);
        end
        pe_sel = 1'b1;
        #1;
        n_vec++;
        if (f_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready_sel1: got %b want 1", f_ready);
        end
    endtask

    task automatic test_latency();
        do_reset();
        ro_ready = 2'b11;
        write_flit(1'b1, 8'hA5);
        n_vec++;
        if (f_en !== 1'b0) begin
            n_err++;
            $display("FAIL latency_c1: en got %b want 0", f_en);
        end
        tick();
        n_vec++;
        if ({f_en, f_data, f_sel} !== {1'b1, 8'hA5, 1'b1}) begin
            n_err++;
            $display("FAIL latency_c2: en/data/sel got %b/%h/%b want 1/a5/1", f_en, f_data, f_sel);
        end
        tick();
        n_vec++;
        if ({f_en, f_data, f_sel} !== {1'b0, 8'hA5, 1'b1}) begin
            n_err++;
            $display("FAIL latency_c3: en/data/sel got %b/%h/%b want 0/a5/1", f_en, f_data, f_sel);
        end
    endtask

    task automatic test_full();
        do_reset();
        ro_ready = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            write_flit(1'b0, 8'(k));
        end
        pe_sel = 1'b0;
        #1;
        n_vec++;
        if ({f_full, f_empty, f_ready} !== {2'b01, 2'b10, 1'b0}) begin
            n_err++;
            $display("FAIL full_flags: full/empty/ready got %b/%b/%b want 01/10/0", f_full, f_empty, f_ready);
        end
        write_flit(1'b0, 8'h05);
        pe_sel = 1'b1;
        #1;
        n_vec++;
        if ({f_full, f_ready} !== {2'b01, 1'b1}) begin
            n_err++;
            $display("FAIL full_other_vc: full/ready(sel1) got %b/%b want 01/1", f_full, f_ready);
        end
        // Release VC0 and try a write in the same cycle: the pre-edge count is full.
        pe_sel   = 1'b0;
        pe_data  = 8'h06;
        pe_en    = 1'b1;
        ro_ready = 2'b01;
        for (int k = 1; k <= 4; k++) begin
            tick();
            pe_en = 1'b0;
            n_vec++;
            if ({f_en, f_data, f_sel} !== {1'b1, 8'(k), 1'b0}) begin
                n_err++;
                $display("FAIL full_drain_%0d: en/data/sel got %b/%h/%b want 1/%h/0", k, f_en, f_data, f_sel, 8'(k));
            end
        end
        tick();
        n_vec++;
        if ({f_en, f_data, f_empty} !== {1'b0, 8'h04, 2'b11}) begin
            n_err++;
            $display("FAIL full_after: en/data/empty got %b/%h/%b want 0/04/11", f_en, f_data, f_empty);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [4];
        logic       exp_s [4];
        exp_d = '{8'h10, 8'h20, 8'h11, 8'h21};
        exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        write_flit(1'b0, 8'h10);
        write_flit(1'b0, 8'h11);
        write_flit(1'b1, 8'h20);
        write_flit(1'b1, 8'h21);
        ro_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_vec++;
            if ({f_en, f_data, f_sel} !== {1'b1, exp_d[k], exp_s[k]}) begin
                n_err++;
                $display("FAIL rr_%0d: en/data/sel got %b/%h/%b want 1/%h/%b", k, f_en, f_data, f_sel, exp_d[k], exp_s[k]);
            end
        end
        tick();
        n_vec++;
        if (f_en !== 1'b0) begin
            n_err++;
            $display("FAIL rr_idle: en got %b want 0", f_en);
        end
    endtask

    task automatic test_back_to_back();
        // Writes on consecutive cycles into VC0 while it drains: push and pop
        // coincide on the same FIFO.
        do_reset();
        ro_ready = 2'b01;
        pe_en    = 1'b1;
        pe_sel   = 1'b0;
        pe_data  = 8'h30;
        tick();
        n_vec++;
        if (f_en !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_c1: en got %b want 0", f_en);
        end
        pe_data = 8'h31;
        tick();
        n_vec++;
        if ({f_en, f_data} !== {1'b1, 8'h30}) begin
            n_err++;
            $display("FAIL b2b_c2: en/data got %b/%h want 1/30", f_en, f_data);
        end
        pe_data = 8'h32;
        tick();
        pe_en = 1'b0;
        n_vec++;
        if ({f_en, f_data} !== {1'b1, 8'h31}) begin
            n_err++;
            $display("FAIL b2b_c3: en/data got %b/%h want 1/31", f_en, f_data);
        end
        tick();
        n_vec++;
        if ({f_en, f_data} !== {1'b1, 8'h32}) begin
            n_err++;
            $display("FAIL b2b_c4: en/data got %b/%h want 1/32", f_en, f_data);
        end
        tick();
        n_vec++;
        if ({f_en, f_empty} !== {1'b0, 2'b11}) begin
            n_err++;
            $display("FAIL b2b_end: en/empty got %b/%b want 0/11", f_en, f_empty);
        end
    endtask

    task automatic fill_packets();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            write_flit(1'b0, 8'h10 + 8'(k));
        end
        for (int k = 0; k < 4; k++) begin
            write_flit(1'b1, 8'h20 + 8'(k));
        end
    endtask

    task automatic test_packet();
        // Ready applied before each edge, and the expected output after it.
        logic [1:0] rdy [11];
        logic       e_en [11];
        logic [7:0] e_d [11];
        logic       e_s [11];
        rdy  = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
        e_en = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        e_d  = '{8'h10, 8'h11, 8'h11, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23, 8'h23};
        e_s  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        fill_packets();
        for (int k = 0; k < 11; k++) begin
            ro_ready = rdy[k];
            tick();
            n_vec++;
            if ({p_en, p_data, p_sel} !== {e_en[k], e_d[k], e_s[k]}) begin
                n_err++;
                $display("FAIL pkt_%0d: en/data/sel got %b/%h/%b want %b/%h/%b",
                         k, p_en, p_data, p_sel, e_en[k], e_d[k], e_s[k]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        fill_packets();
        ro_ready = 2'b11;
        tick();
        tick();
        n_vec++;
        if ({p_en, p_data, p_sel} !== {1'b1, 8'h11, 1'b0}) begin
            n_err++;
            $display("FAIL midrst_pre: en/data/sel got %b/%h/%b want 1/11/0", p_en, p_data, p_sel);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++;
        if ({p_en, p_data, p_sel, p_empty} !== {1'b0, 8'h00, 1'b0, 2'b11}) begin
            n_err++;
            $display("FAIL midrst_state: en/data/sel/empty got %b/%h/%b/%b want 0/00/0/11", p_en, p_data, p_sel, p_empty);
        end
        tick();
        n_vec++;
        if (p_en !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_quiet: en got %b want 0", p_en);
        end
        write_flit(1'b1, 8'h77);
        n_vec++;
        if (p_en !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_c1: en got %b want 0", p_en);
        end
        tick();
        n_vec++;
        if ({p_en, p_data, p_sel} !== {1'b1, 8'h77, 1'b1}) begin
            n_err++;
            $display("FAIL midrst_c2: en/data/sel got %b/%h/%b want 1/77/1", p_en, p_data, p_sel);
        end
    endtask

    initial begin
        reset    = 1'b1;
        pe_en    = 1'b0;
        pe_sel   = 1'b0;
        pe_data  = 8'h00;
        ro_ready = 2'b00;
        test_reset();
        test_latency();
        test_full();
        test_round_robin();
        test_back_to_back();
        test_packet();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
